// File: rtl/shiftreg_led.sv
// LED pattern shift register. The asynchronous rate signal clk_trl is
// synchronised into the clk domain, and each rising edge becomes a one-cycle
// step that rotates, bounces or holds the LED pattern. clk_trl is only ever
// sampled as data.
module shiftreg_led #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_trl,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             step
);

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  // fill_q[1] is set once s2 holds a real sample of clk_trl rather than its
  // reset zero; without it a clk_trl held high through reset release would
  // look like a fresh low-to-high transition and arm the block falsely.
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;

  logic rise;
  logic accept;

  assign rise   = s2_q & ~s3_q;
  assign accept = rise & armed_q & en;

  // Next-state: synchroniser and arming always run; pattern follows load > step > hold.
  always_comb begin
    s1_d    = clk_trl;
    s2_d    = s1_q;
    s3_d    = s2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = 1'b0;

    if (load) begin
      // A rise coinciding with a load is consumed here and never applied.
      led_d = load_val;
    end else if (accept) begin
      step_d = 1'b1;
      if (mode != 2'b11) begin
        if (led_q == '0) begin
          led_d = INIT;
        end else begin
          case (mode)
            MODE_ROTL: begin
              led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              dir_d = 1'b0;
            end
            MODE_ROTR: begin
              led_d = {led_q[0], led_q[WIDTH-1:1]};
              dir_d = 1'b1;
            end
            MODE_BOUNCE: begin
              if (!dir_q && led_q[WIDTH-1]) begin
                dir_d = 1'b1;
                led_d = led_q >> 1;
              end else if (dir_q && led_q[0]) begin
                dir_d = 1'b0;
                led_d = led_q << 1;
              end else if (dir_q) begin
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end
            default: begin
              led_d = led_q;
            end
          endcase
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      led_q   <= INIT;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  assign led  = led_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule

// File: tb/tb_shiftreg_led.sv
// Bench for shiftreg_led: directed scenarios followed by randomised pulses,
// all checked against an arithmetic model of the pattern rules.
module tb_shiftreg_led;

  localparam int WIDTH = 8;
  localparam longint M = longint'(1) << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_trl;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] led;
  logic             dir;
  logic             step;

  int total = 0;
  int bad   = 0;

  longint exp_led;
  int     exp_dir;

  shiftreg_led #(.WIDTH(WIDTH), .INIT(8'h01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_trl  (clk_trl),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .dir      (dir),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the pattern as an integer in [0, 2^WIDTH), updated by one step.
  task automatic model_step(input int md);
    if (md == 3) return;
    if (exp_led == 0) begin
      exp_led = 1;
      return;
    end
    case (md)
      0: begin
        exp_led = (exp_led * 2) % M + exp_led / (M / 2);
        exp_dir = 0;
      end
      1: begin
        exp_led = exp_led / 2 + (exp_led % 2) * (M / 2);
        exp_dir = 1;
      end
      default: begin
        if (exp_dir == 0 && exp_led >= M / 2) begin
          exp_dir = 1;
          exp_led = exp_led / 2;
        end else if (exp_dir == 1 && exp_led % 2 == 1) begin
          exp_dir = 0;
          exp_led = (exp_led * 2) % M;
        end else if (exp_dir == 1) begin
          exp_led = exp_led / 2;
        end else begin
          exp_led = (exp_led * 2) % M;
        end
      end
    endcase
  endtask

  // One clk_trl pulse: hi cycles high then lo cycles low. The step must land
  // on the third sampled edge after clk_trl was raised.
  task automatic pulse(input int hi, input int lo, input bit expect_step);
    int nsteps = 0;
    int at = 0;
    clk_trl = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      if (i == hi + 1) clk_trl = 1'b0;
      tick();
      if (step === 1'b1) begin
        nsteps++;
        at = i;
      end
    end
    chk("step_count", nsteps, expect_step ? 1 : 0);
    if (expect_step) begin
      chk("step_latency", at, 3);
      model_step(int'(mode));
    end
    chk("led", longint'(led), exp_led);
    chk("dir", longint'(dir), longint'(exp_dir));
    $display("pulse mode=%0d en=%0b led=%02h dir=%0b steps=%0d", mode, en, led, dir, nsteps);
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
    exp_led = longint'(v);
    chk("load_led", longint'(led), exp_led);
    chk("load_step", longint'(step), 0);
    $display("load val=%02h led=%02h", v, led);
  endtask

  initial begin
    rst_n    = 1'b0;
    clk_trl  = 1'b1;
    en       = 1'b1;
    mode     = 2'b00;
    load     = 1'b0;
    load_val = '0;
    exp_led  = 1;
    exp_dir  = 0;

    // Reset with clk_trl held high.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_led", longint'(led), 1);
      chk("rst_step", longint'(step), 0);
      chk("rst_dir", longint'(dir), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_high_step", longint'(step), 0);
      chk("held_high_led", longint'(led), 1);
    end
    clk_trl = 1'b0;
    tick();
    tick();
    // 4-cycle-period square wave.
    for (int i = 0; i < 3; i++) pulse(2, 2, 1'b1);
    chk("square_led", longint'(led), 8'h08);

    // Rotate left from 01, nine steps.
    do_load(8'h01);
    tick();
    for (int i = 0; i < 9; i++) pulse(3, 3, 1'b1);
    chk("rotl_final", longint'(led), 8'h02);

    // Bounce off the top, then off the bottom.
    do_load(8'h80);
    mode = 2'b10;
    for (int i = 0; i < 3; i++) pulse(3, 3, 1'b1);
    chk("bounce_top_led", longint'(led), 8'h10);
    chk("bounce_top_dir", longint'(dir), 1);
    do_load(8'h01);
    pulse(3, 3, 1'b1);
    chk("bounce_bot_led", longint'(led), 8'h02);
    chk("bounce_bot_dir", longint'(dir), 0);

    // Load collides with a rise: load wins, rise is lost.
    clk_trl = 1'b1;
    tick();
    tick();
    load     = 1'b1;
    load_val = 8'hA5;
    tick();
    load = 1'b0;
    exp_led = 8'hA5;
    chk("collide_led", longint'(led), 8'hA5);
    chk("collide_step", longint'(step), 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) clk_trl = 1'b0;
      tick();
      chk("collide_nostep", longint'(step), 0);
      chk("collide_hold", longint'(led), 8'hA5);
    end
    $display("collision led=%02h step=%0b", led, step);

    // All-zero recovery, then disable and re-enable.
    do_load(8'h00);
    mode = 2'b01;
    pulse(3, 3, 1'b1);
    chk("recover_led", longint'(led), 8'h01);
    en = 1'b0;
    for (int i = 0; i < 5; i++) pulse(3, 3, 1'b0);
    en = 1'b1;
    pulse(3, 3, 1'b1);
    chk("reenable_led", longint'(led), 8'h80);

    // Reset while a rise is in the synchroniser.
    clk_trl = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_led = 1;
    exp_dir = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_step", longint'(step), 0);
      chk("midrst_led", longint'(led), 1);
    end
    clk_trl = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pulse(3, 3, 1'b1);

    // Randomised modes, enables and loads.
    for (int n = 0; n < 24; n++) begin
      mode = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) do_load(WIDTH'($urandom_range(0, 255)));
      pulse($urandom_range(3, 5), $urandom_range(3, 5), en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
